// File: rtl/instruction_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_pkg
//   Shared definitions for the fetch stage: default widths, reset PC,
//   instruction field positions, control-group / HALT encodings, the fetch
//   FSM state type and a helper that recognises a HALT word.
//   No ports (package).
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 8'h00;

  // Command group sits in the top three bits, command in the next four.
  localparam int GROUP_MSB = 31;
  localparam int GROUP_W   = 3;
  localparam int CMD_MSB   = 28;
  localparam int CMD_W     = 4;

  localparam logic [GROUP_W-1:0] GRP_CTRL = 3'b111;
  localparam logic [CMD_W-1:0]   CMD_HALT = 4'b1111;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

  // True when the word is the control-group HALT command.
  function automatic logic is_halt_word(input logic [INSTR_W-1:0] word);
    return (word[GROUP_MSB -: GROUP_W] == GRP_CTRL) &&
           (word[CMD_MSB -: CMD_W] == CMD_HALT);
  endfunction

endpackage

// File: rtl/instruction_fetch_skid.sv
// ---------------------------------------------------------------------------
// fetch_skid_buffer
//   One-entry holding register for a fetched {word, pc} pair that returned
//   from the ROM while the output register was occupied and not accepted.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   push         load push_word/push_pc into the entry
//   pop          entry consumed by the output register this cycle
//   flush        discard the entry (jump / halt); wins over push and pop
//   push_word    instruction word to store
//   push_pc      address of push_word
//   full         entry holds a valid word
//   word, pc     stored entry
// ---------------------------------------------------------------------------
module fetch_skid_buffer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] push_word,
  input  logic [ADDR_WIDTH-1:0]  push_pc,
  output logic                   full,
  output logic [INSTR_WIDTH-1:0] word,
  output logic [ADDR_WIDTH-1:0]  pc
);

  // A push in the same cycle as a pop replaces the entry, so a stream can
  // pass through the skid at full rate while the output is reloading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      word <= '0;
      pc   <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
      word <= push_word;
      pc   <= push_pc;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage: owns the PC, reads a synchronous instruction ROM and hands
//   one word per cycle to the splitter over a valid/ready handshake. Copes
//   with back-pressure (output register + one skid entry), jump redirects
//   and HALT.
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   imem_addr      ROM read address (current PC)
//   imem_rd_en     ROM read strobe
//   imem_rdata     ROM data, valid the cycle after imem_rd_en
//   jump_valid     one-cycle redirect request
//   jump_target    redirect address
//   instr_ready    downstream accepts the word this cycle
//   instruction    fetched word
//   instr_pc       address of the fetched word
//   instr_valid    instruction/instr_pc valid
//   halted         fetch stopped on HALT
// ---------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = ADDR_W,
  parameter int                    INSTR_WIDTH = INSTR_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic                   imem_rd_en,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   jump_valid,
  input  logic [ADDR_WIDTH-1:0]  jump_target,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  output logic                   halted
);

  fetch_state_t            state_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [ADDR_WIDTH-1:0]   inflight_pc_q;
  logic                    inflight_q;

  logic                    accept;
  logic                    halt_accept;
  logic                    out_free;
  logic [1:0]              occ_next;
  logic                    room;
  logic                    issue;

  logic                    skid_full;
  logic                    skid_push;
  logic                    skid_pop;
  logic                    skid_flush;
  logic [INSTR_WIDTH-1:0]  skid_word;
  logic [ADDR_WIDTH-1:0]   skid_pc;

  assign accept      = instr_valid && instr_ready;
  assign halt_accept = accept && (state_q == S_RUN) && is_halt_word(instruction);
  assign out_free    = !instr_valid || accept;

  // Words that will still be held after this edge: output, skid and the
  // request now returning from the ROM, minus the one being accepted. A new
  // request lands one cycle later, so it may only be issued when at most one
  // of the two storage slots is spoken for; otherwise a stall arriving while
  // a word is in flight would overflow the skid. accept implies instr_valid,
  // so the subtraction never wraps.
  assign occ_next = {1'b0, instr_valid} + {1'b0, skid_full} + {1'b0, inflight_q}
                  - {1'b0, accept};
  assign room     = (occ_next <= 2'd1);

  // Jump and HALT acceptance both suppress issue in their own cycle.
  assign issue = (state_q == S_RUN) && room && !jump_valid && !halt_accept;

  assign imem_rd_en = issue;
  assign imem_addr  = pc_q;

  // The returning word goes straight to the output register when that is
  // free and nothing older is waiting in the skid; otherwise it is parked.
  assign skid_flush = jump_valid || halt_accept;
  assign skid_pop   = out_free && skid_full;
  assign skid_push  = inflight_q && !(out_free && !skid_full);

  fetch_skid_buffer #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (skid_push),
    .pop       (skid_pop),
    .flush     (skid_flush),
    .push_word (imem_rdata),
    .push_pc   (inflight_pc_q),
    .full      (skid_full),
    .word      (skid_word),
    .pc        (skid_pc)
  );

  // Fetch FSM, PC, in-flight tracking and the registered output stage.
  // A jump overrides everything, including a HALT accepted the same cycle.
  // HALT discards anything fetched past it; otherwise the output reloads
  // from the skid before taking fresh ROM data so order is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_START;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      instruction   <= '0;
      instr_pc      <= '0;
      instr_valid   <= 1'b0;
      halted        <= 1'b0;
    end else if (jump_valid) begin
      state_q     <= S_RUN;
      pc_q        <= jump_target;
      inflight_q  <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state_q)
        S_START: state_q <= S_RUN;
        S_RUN: begin
          if (halt_accept) begin
            state_q <= S_HALT;
            halted  <= 1'b1;
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_START;
      endcase

      if (halt_accept) begin
        instr_valid <= 1'b0;
        inflight_q  <= 1'b0;
      end else begin
        if (out_free) begin
          if (skid_full) begin
            instruction <= skid_word;
            instr_pc    <= skid_pc;
            instr_valid <= 1'b1;
          end else if (inflight_q) begin
            instruction <= imem_rdata;
            instr_pc    <= inflight_pc_q;
            instr_valid <= 1'b1;
          end else begin
            instr_valid <= 1'b0;
          end
        end

        inflight_q <= issue;
        if (issue) begin
          pc_q          <= pc_q + ADDR_WIDTH'(1);
          inflight_pc_q <= pc_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed bench for instruction_fetch with a behavioural synchronous ROM
//   and a scoreboard of expected {pc, word} pairs consumed on each accepted
//   handshake.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] HALT_WORD = 32'hFE00_0000;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] word;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata = '0;
  logic        jump_valid;
  logic [7:0]  jump_target;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        halted;

  logic [31:0] rom [256];
  exp_t        sb[$];
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  // Synchronous ROM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= rom[imem_addr];
  end

  instruction_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_rd_en  (imem_rd_en),
    .imem_rdata  (imem_rdata),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {31'h0, obs}, {31'h0, exp});
  endtask

  task automatic expect_range(input logic [7:0] start, input int n);
    logic [7:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{pc: p, word: rom[p]});
      p = p + 8'd1;
    end
  endtask

  // One clock cycle: drive inputs, score any accepted word, advance.
  task automatic step(input logic rdy, input logic jv, input logic [7:0] jt);
    exp_t e;
    instr_ready = rdy;
    jump_valid  = jv;
    jump_target = jt;
    #1;
    if (instr_valid && instr_ready) begin
      compared++;
      assert (sb.size() > 0) else begin
        mismatched++;
        $error("[TB] FAIL sb_extra_word observed pc=%h expected none", instr_pc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("deliver_pc", {24'h0, instr_pc}, {24'h0, e.pc});
        check("deliver_word", instruction, e.word);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 8'h00);
      check1("stream_no_gap", instr_valid, 1'b1);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'(i);
    instr_ready = 1'b0;
    jump_valid  = 1'b0;
    jump_target = 8'h00;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_valid", instr_valid, 1'b0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_pc", {24'h0, instr_pc}, 32'h0);
    check1("rst_halted", halted, 1'b0);
    check1("rst_rd_en", imem_rd_en, 1'b0);
    check("rst_addr", {24'h0, imem_addr}, 32'h0);
    rst_n = 1'b1;

    // First word three cycles after reset release, then one per cycle
    expect_range(8'h00, 12);
    step(1'b1, 1'b0, 8'h00);
    check1("start_c1_no_valid", instr_valid, 1'b0);
    step(1'b1, 1'b0, 8'h00);
    check1("start_c2_no_valid", instr_valid, 1'b0);
    step(1'b1, 1'b0, 8'h00);
    check1("start_c3_valid", instr_valid, 1'b1);
    check("start_first_pc", {24'h0, instr_pc}, 32'h0);
    stream(4);
    check("stall_head_pc", {24'h0, instr_pc}, 32'h4);

    // Back-pressure for five cycles: word@4 held, fetch stops once the skid fills
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'h00);
      check1("stall_valid_held", instr_valid, 1'b1);
      check("stall_pc_held", {24'h0, instr_pc}, 32'h4);
      check("stall_word_held", instruction, rom[4]);
      check1("stall_rd_en_low", imem_rd_en, 1'b0);
    end
    stream(6);

    // Jump while the skid is full and ready is low
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check1("prejump_rd_en_low", imem_rd_en, 1'b0);
    sb.delete();
    expect_range(8'h40, 8);
    step(1'b0, 1'b1, 8'h40);
    check1("jump_flush_valid", instr_valid, 1'b0);
    step(1'b1, 1'b0, 8'h00);
    check1("jump_c2_no_valid", instr_valid, 1'b0);
    step(1'b1, 1'b0, 8'h00);
    check1("jump_c3_valid", instr_valid, 1'b1);
    check("jump_first_pc", {24'h0, instr_pc}, 32'h40);
    stream(3);

    // HALT at address 3
    rom[3] = HALT_WORD;
    sb.delete();
    expect_range(8'h00, 4);
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("halt_run_pc0", {24'h0, instr_pc}, 32'h0);
    stream(3);
    check("halt_word_presented", instruction, HALT_WORD);
    step(1'b1, 1'b0, 8'h00);
    check1("halt_halted", halted, 1'b1);
    check1("halt_valid_low", instr_valid, 1'b0);
    check1("halt_rd_en_low", imem_rd_en, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 8'h00);
      check1("halt_stays_halted", halted, 1'b1);
      check1("halt_stays_invalid", instr_valid, 1'b0);
      check1("halt_stays_idle", imem_rd_en, 1'b0);
    end
    check("halt_queue_drained", 32'(sb.size()), 32'h0);

    // Resume from HALT with a jump to 8'h10
    rom[3] = 32'h3;
    sb.delete();
    expect_range(8'h10, 6);
    step(1'b0, 1'b1, 8'h10);
    check1("resume_halted_clear", halted, 1'b0);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check1("resume_valid", instr_valid, 1'b1);
    check("resume_pc", {24'h0, instr_pc}, 32'h10);
    stream(3);

    // PC wrap FE, FF, 00, 01
    sb.delete();
    expect_range(8'hFE, 5);
    step(1'b0, 1'b1, 8'hFE);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("wrap_first_pc", {24'h0, instr_pc}, 32'hFE);
    stream(4);
    check("wrap_after_pc", {24'h0, instr_pc}, 32'h02);

    // Asynchronous reset mid-stream with the skid full
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check1("prereset_valid", instr_valid, 1'b1);
    rst_n = 1'b0;
    #2;
    check1("async_rst_valid", instr_valid, 1'b0);
    check("async_rst_instruction", instruction, 32'h0);
    check("async_rst_pc", {24'h0, instr_pc}, 32'h0);
    check1("async_rst_halted", halted, 1'b0);
    check1("async_rst_rd_en", imem_rd_en, 1'b0);
    check("async_rst_addr", {24'h0, imem_addr}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    expect_range(8'h00, 6);
    step(1'b1, 1'b0, 8'h00);
    check1("refetch_c1_no_valid", instr_valid, 1'b0);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check1("refetch_valid", instr_valid, 1'b1);
    check("refetch_pc", {24'h0, instr_pc}, 32'h0);
    stream(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
